// File: rtl/score_pkg.sv
// Shared types and constants for the score controller slice.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PLAY       = 2'b01,
        OVER_BLINK = 2'b10,
        OVER_HOLD  = 2'b11
    } state_t;

    localparam int unsigned REQ_HIT   = 0;
    localparam int unsigned REQ_BONUS = 1;
    localparam int unsigned REQ_MISS  = 2;
    localparam int unsigned N_REQ     = 3;
    localparam int unsigned SCORE_W   = 7;

endpackage

// File: rtl/score_if.sv
// Game-control, point-request handshake and display signals of the score controller.
interface score_if;
    import score_pkg::*;

    logic               start;
    logic               game_end;
    logic               hit_req;
    logic               hit_ack;
    logic               bonus_req;
    logic               bonus_ack;
    logic               miss_req;
    logic               miss_ack;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               disp_sel;
    logic               disp_blank;
    logic               new_high;
    logic [1:0]         state;

    modport master (
        output start, game_end, hit_req, bonus_req, miss_req,
        input  hit_ack, bonus_ack, miss_ack, score, high_score,
               disp_sel, disp_blank, new_high, state
    );

    modport slave (
        input  start, game_end, hit_req, bonus_req, miss_req,
        output hit_ack, bonus_ack, miss_ack, score, high_score,
               disp_sel, disp_blank, new_high, state
    );

endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter; the pointer names the first requester searched.
module rr_arb3
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    logic [1:0]       ptr_q;
    logic [N_REQ-1:0] elig;

    assign elig = req & ~mask;

    // Priority rotates with the pointer: hit -> bonus -> miss -> hit.
    always_comb begin
        grant = '0;
        case (ptr_q)
            2'(REQ_HIT): begin
                if      (elig[REQ_HIT])   grant[REQ_HIT]   = 1'b1;
                else if (elig[REQ_BONUS]) grant[REQ_BONUS] = 1'b1;
                else if (elig[REQ_MISS])  grant[REQ_MISS]  = 1'b1;
            end
            2'(REQ_BONUS): begin
                if      (elig[REQ_BONUS]) grant[REQ_BONUS] = 1'b1;
                else if (elig[REQ_MISS])  grant[REQ_MISS]  = 1'b1;
                else if (elig[REQ_HIT])   grant[REQ_HIT]   = 1'b1;
            end
            default: begin
                if      (elig[REQ_MISS])  grant[REQ_MISS]  = 1'b1;
                else if (elig[REQ_HIT])   grant[REQ_HIT]   = 1'b1;
                else if (elig[REQ_BONUS]) grant[REQ_BONUS] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'(REQ_HIT);
        end else if (advance) begin
            if      (grant[REQ_HIT])   ptr_q <= 2'(REQ_BONUS);
            else if (grant[REQ_BONUS]) ptr_q <= 2'(REQ_MISS);
            else if (grant[REQ_MISS])  ptr_q <= 2'(REQ_HIT);
        end
    end

endmodule

// File: rtl/score_controller.sv
// Game-phase sequencer owning the score, high score, point arbitration and display control.
module score_controller
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = 99,
    parameter int unsigned HIT_PTS     = 1,
    parameter int unsigned BONUS_PTS   = 5,
    parameter int unsigned MISS_PTS    = 2,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned OVER_BLINKS = 6
) (
    input  logic clk,
    input  logic clr,
    score_if.slave bus
);

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam int unsigned TOG_W   = $clog2(OVER_BLINKS + 1);

    state_t             state_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] high_q;
    logic [N_REQ-1:0]   ack_q;
    logic               sel_q;
    logic               blank_q;
    logic               new_high_q;
    logic [BLINK_W-1:0] blink_q;
    logic [TOG_W-1:0]   tog_q;

    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   grant;
    logic               advance;
    logic               restart;

    assign req     = {bus.miss_req, bus.bonus_req, bus.hit_req};
    assign advance = (state_q == PLAY) && !bus.game_end;
    assign restart = bus.start && (state_q != PLAY);

    rr_arb3 u_arb (
        .clk     (clk),
        .rst_n   (clr),
        .req     (req),
        .mask    (ack_q),
        .advance (advance),
        .grant   (grant)
    );

    // Saturating add through an 8-bit intermediate.
    function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] s,
                                                   input int unsigned pts);
        logic [7:0] sum;
        sum = {1'b0, s} + 8'(pts);
        return (sum > 8'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            score_q    <= '0;
            high_q     <= '0;
            ack_q      <= '0;
            sel_q      <= 1'b1;
            blank_q    <= 1'b0;
            new_high_q <= 1'b0;
            blink_q    <= '0;
            tog_q      <= '0;
        end else begin
            ack_q <= '0;
            if (restart) begin
                state_q    <= PLAY;
                score_q    <= '0;
                new_high_q <= 1'b0;
                sel_q      <= 1'b0;
                blank_q    <= 1'b0;
                blink_q    <= '0;
                tog_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sel_q   <= 1'b1;
                        score_q <= '0;
                    end
                    PLAY: begin
                        if (bus.game_end) begin
                            state_q <= OVER_BLINK;
                            blank_q <= 1'b0;
                            blink_q <= '0;
                            tog_q   <= '0;
                            if (score_q > high_q) begin
                                high_q     <= score_q;
                                new_high_q <= 1'b1;
                            end
                        end else begin
                            ack_q <= grant;
                            if (grant[REQ_HIT])
                                score_q <= add_sat(score_q, HIT_PTS);
                            else if (grant[REQ_BONUS])
                                score_q <= add_sat(score_q, BONUS_PTS);
                            else if (grant[REQ_MISS])
                                score_q <= (score_q < SCORE_W'(MISS_PTS)) ? '0
                                           : score_q - SCORE_W'(MISS_PTS);
                        end
                    end
                    OVER_BLINK: begin
                        // The final toggle lands the display steady-on and hands over to hold.
                        if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
                            blink_q <= '0;
                            if (tog_q == TOG_W'(OVER_BLINKS - 1)) begin
                                blank_q <= 1'b0;
                                tog_q   <= '0;
                                state_q <= OVER_HOLD;
                            end else begin
                                blank_q <= ~blank_q;
                                tog_q   <= tog_q + 1'b1;
                            end
                        end else begin
                            blink_q <= blink_q + 1'b1;
                        end
                    end
                    OVER_HOLD: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.hit_ack    = ack_q[REQ_HIT];
    assign bus.bonus_ack  = ack_q[REQ_BONUS];
    assign bus.miss_ack   = ack_q[REQ_MISS];
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.disp_sel   = sel_q;
    assign bus.disp_blank = blank_q;
    assign bus.new_high   = new_high_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_score_controller.sv
// Self-checking bench for score_controller with a fast blink setting and a game-rule model.
module tb_score_controller;
    import score_pkg::*;

    localparam int BD = 4;
    localparam int OB = 6;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    score_if bus ();

    score_controller #(.BLINK_DIV(BD), .OVER_BLINKS(OB)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 play, 2 game over (blink/hold derived from m_over).
    int       m_phase, m_score, m_high, m_ptr, m_over;
    bit       m_new_high;
    bit [2:0] m_ack;

    wire [2:0]  acks    = {bus.miss_ack, bus.bonus_ack, bus.hit_ack};
    wire [21:0] got_vec = {bus.state, bus.score, bus.high_score, bus.disp_sel,
                           bus.disp_blank, bus.new_high, acks};
    localparam logic [21:0] RESET_VEC = {2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 3'b000};

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_high = 0; m_ptr = 0; m_over = 0;
        m_new_high = 0; m_ack = '0;
    endtask

    function automatic int exp_state();
        if (m_phase == 2) return (m_over >= BD * OB) ? 3 : 2;
        return m_phase;
    endfunction

    function automatic bit exp_blank();
        if (m_phase != 2 || m_over >= BD * OB) return 1'b0;
        return bit'((m_over / BD) % 2);
    endfunction

    function automatic logic [21:0] exp_vec();
        return {2'(exp_state()), 7'(m_score), 7'(m_high), (m_phase == 0),
                exp_blank(), m_new_high, m_ack};
    endfunction

    // Apply the game rules to the inputs about to be sampled at the next edge.
    task automatic model_step();
        bit [2:0] r;
        bit [2:0] prev;
        r    = {bus.miss_req, bus.bonus_req, bus.hit_req};
        prev = m_ack;
        m_ack = '0;
        if (m_phase != 1) begin
            if (bus.start) begin
                m_phase = 1; m_score = 0; m_new_high = 0;
            end else if (m_phase == 2 && m_over < BD * OB) begin
                m_over++;
            end
        end else if (bus.game_end) begin
            m_phase = 2; m_over = 0;
            if (m_score > m_high) begin m_high = m_score; m_new_high = 1; end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (r[i] && !prev[i]) begin
                    m_ack[i] = 1'b1;
                    if (i == 0)      m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                    else if (i == 1) m_score = (m_score + 5 > 99) ? 99 : m_score + 5;
                    else             m_score = (m_score < 2) ? 0 : m_score - 2;
                    m_ptr = (i + 1) % 3;
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v);
        case (idx)
            0:       bus.hit_req   = v;
            1:       bus.bonus_req = v;
            default: bus.miss_req  = v;
        endcase
    endtask

    function automatic logic get_req(input int idx);
        case (idx)
            0:       return bus.hit_req;
            1:       return bus.bonus_req;
            default: return bus.miss_req;
        endcase
    endfunction

    task automatic grant_one(input int idx);
        set_req(idx, 1'b1); cycle();
        set_req(idx, 1'b0); cycle();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.game_end = 1'b1; cycle(); bus.game_end = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_values: got %h expected %h", got_vec, RESET_VEC);
        end
        clr = 1'b1;
        cycle();
        checks++;
        if (got_vec !== RESET_VEC) begin
            errors++; $display("FAIL idle_after_release: got %h expected %h", got_vec, RESET_VEC);
        end
        bus.hit_req = 1'b1;
        repeat (20) begin
            cycle();
            checks++;
            if (bus.hit_ack !== 1'b0 || bus.state !== 2'd0) begin
                errors++;
                $display("FAIL idle_no_ack: ack=%b state=%0d expected ack=0 state=0",
                         bus.hit_ack, bus.state);
            end
        end
        bus.hit_req = 1'b0;
    endtask

    task automatic test_handshake();
        pulse_start();
        checks++;
        if (bus.state !== 2'd1 || bus.score !== 7'd0 || bus.disp_sel !== 1'b0) begin
            errors++;
            $display("FAIL play_entry: state=%0d score=%0d sel=%b expected 1/0/0",
                     bus.state, bus.score, bus.disp_sel);
        end
        bus.hit_req = 1'b1;
        cycle();
        checks++;
        if (bus.hit_ack !== 1'b1 || bus.score !== 7'd1) begin
            errors++;
            $display("FAIL hs_grant: ack=%b score=%0d expected 1/1", bus.hit_ack, bus.score);
        end
        cycle();
        checks++;
        if (bus.hit_ack !== 1'b0 || bus.score !== 7'd1) begin
            errors++;
            $display("FAIL hs_masked: ack=%b score=%0d expected 0/1", bus.hit_ack, bus.score);
        end
        bus.hit_req = 1'b0;
        cycle();
        checks++;
        if (acks !== 3'b000 || bus.score !== 7'd1) begin
            errors++;
            $display("FAIL hs_idle: acks=%b score=%0d expected 000/1", acks, bus.score);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack [4];
        int         exp_sc  [4];
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_sc  = '{11, 16, 14, 15};
        grant_one(1); grant_one(1); grant_one(0); grant_one(2);
        checks++;
        if (bus.score !== 7'd10) begin
            errors++; $display("FAIL rr_setup: score=%0d expected 10", bus.score);
        end
        bus.hit_req = 1'b1; bus.bonus_req = 1'b1; bus.miss_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (acks !== exp_ack[i] || bus.score !== 7'(exp_sc[i])) begin
                errors++;
                $display("FAIL rr_step%0d: acks=%b score=%0d expected %b/%0d",
                         i, acks, bus.score, exp_ack[i], exp_sc[i]);
            end
        end
        bus.hit_req = 1'b0; bus.bonus_req = 1'b0; bus.miss_req = 1'b0;
        cycle();
    endtask

    task automatic test_game_over();
        bus.bonus_req = 1'b1;
        pulse_end();
        checks++;
        if (bus.bonus_ack !== 1'b0 || bus.state !== 2'd2 || bus.high_score !== 7'd15 ||
            bus.new_high !== 1'b1 || bus.score !== 7'd15) begin
            errors++;
            $display("FAIL over_entry: ack=%b state=%0d high=%0d new=%b score=%0d expected 0/2/15/1/15",
                     bus.bonus_ack, bus.state, bus.high_score, bus.new_high, bus.score);
        end
        repeat (3) begin
            cycle();
            checks++;
            if (bus.bonus_ack !== 1'b0) begin
                errors++; $display("FAIL over_no_ack: ack=%b expected 0", bus.bonus_ack);
            end
        end
        bus.bonus_req = 1'b0;
        pulse_start();
        checks++;
        if (bus.state !== 2'd1 || bus.score !== 7'd0 || bus.new_high !== 1'b0 ||
            bus.high_score !== 7'd15) begin
            errors++;
            $display("FAIL restart: state=%0d score=%0d new=%b high=%0d expected 1/0/0/15",
                     bus.state, bus.score, bus.new_high, bus.high_score);
        end
        repeat (3) grant_one(1);
        pulse_end();
        checks++;
        if (bus.state !== 2'd2 || bus.high_score !== 7'd15 || bus.new_high !== 1'b0) begin
            errors++;
            $display("FAIL equal_high: state=%0d high=%0d new=%b expected 2/15/0",
                     bus.state, bus.high_score, bus.new_high);
        end
    endtask

    task automatic test_blink();
        for (int k = 1; k <= 30; k++) begin
            logic [1:0] es;
            logic       eb;
            cycle();
            es = (k < BD * OB) ? 2'd2 : 2'd3;
            eb = (k < BD * OB) ? logic'((k / BD) % 2) : 1'b0;
            checks++;
            if (bus.state !== es || bus.disp_blank !== eb) begin
                errors++;
                $display("FAIL blink_k%0d: state=%0d blank=%b expected %0d/%b",
                         k, bus.state, bus.disp_blank, es, eb);
            end
        end
        pulse_start();
        checks++;
        if (bus.state !== 2'd1 || bus.score !== 7'd0 || bus.disp_blank !== 1'b0) begin
            errors++;
            $display("FAIL hold_restart: state=%0d score=%0d blank=%b expected 1/0/0",
                     bus.state, bus.score, bus.disp_blank);
        end
        pulse_end();
        repeat (5) cycle();
        checks++;
        if (bus.state !== 2'd2 || bus.disp_blank !== 1'b1) begin
            errors++;
            $display("FAIL mid_blink: state=%0d blank=%b expected 2/1", bus.state, bus.disp_blank);
        end
        pulse_start();
        checks++;
        if (bus.state !== 2'd1 || bus.score !== 7'd0 || bus.disp_blank !== 1'b0 ||
            bus.disp_sel !== 1'b0) begin
            errors++;
            $display("FAIL blink_restart: state=%0d score=%0d blank=%b sel=%b expected 1/0/0/0",
                     bus.state, bus.score, bus.disp_blank, bus.disp_sel);
        end
    endtask

    task automatic test_saturation();
        grant_one(0);
        for (int i = 0; i < 2; i++) begin
            bus.miss_req = 1'b1;
            cycle();
            checks++;
            if (bus.miss_ack !== 1'b1 || bus.score !== 7'd0) begin
                errors++;
                $display("FAIL floor%0d: ack=%b score=%0d expected 1/0", i, bus.miss_ack, bus.score);
            end
            bus.miss_req = 1'b0;
            cycle();
        end
        repeat (19) grant_one(1);
        repeat (2) grant_one(0);
        checks++;
        if (bus.score !== 7'd97) begin
            errors++; $display("FAIL sat_setup: score=%0d expected 97", bus.score);
        end
        bus.bonus_req = 1'b1;
        cycle();
        checks++;
        if (bus.bonus_ack !== 1'b1 || bus.score !== 7'd99) begin
            errors++;
            $display("FAIL sat_bonus: ack=%b score=%0d expected 1/99", bus.bonus_ack, bus.score);
        end
        bus.bonus_req = 1'b0;
        cycle();
        bus.hit_req = 1'b1;
        cycle();
        checks++;
        if (bus.hit_ack !== 1'b1 || bus.score !== 7'd99) begin
            errors++;
            $display("FAIL sat_hit: ack=%b score=%0d expected 1/99", bus.hit_ack, bus.score);
        end
        bus.hit_req = 1'b0;
        cycle();
        pulse_start();
        checks++;
        if (bus.state !== 2'd1 || bus.score !== 7'd99) begin
            errors++;
            $display("FAIL start_in_play: state=%0d score=%0d expected 1/99", bus.state, bus.score);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!get_req(i)) begin
                    if ($urandom_range(3) == 0) set_req(i, 1'b1);
                end else if (acks[i] && $urandom_range(3) != 0) begin
                    set_req(i, 1'b0);
                end
            end
            bus.start    = ($urandom_range(19) == 0);
            bus.game_end = ($urandom_range(24) == 0);
            cycle();
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_n%0d: got %h expected %h", n, got_vec, exp_vec());
            end
        end
        bus.start = 1'b0; bus.game_end = 1'b0;
        bus.hit_req = 1'b0; bus.bonus_req = 1'b0; bus.miss_req = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        bus.hit_req = 1'b1;
        cycle();
        checks++;
        if (bus.hit_ack !== 1'b1) begin
            errors++; $display("FAIL pre_reset_ack: ack=%b expected 1", bus.hit_ack);
        end
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_vec !== RESET_VEC) begin
            errors++; $display("FAIL async_reset: got %h expected %h", got_vec, RESET_VEC);
        end
        bus.hit_req = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        cycle();
        checks++;
        if (got_vec !== RESET_VEC) begin
            errors++; $display("FAIL post_reset_idle: got %h expected %h", got_vec, RESET_VEC);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        bus.start = 1'b0; bus.game_end = 1'b0;
        bus.hit_req = 1'b0; bus.bonus_req = 1'b0; bus.miss_req = 1'b0;
        model_reset();
        test_reset();
        test_handshake();
        test_round_robin();
        test_game_over();
        test_blink();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-level controller that owns the 7-bit score register driving the 3-digit seven-segment score display.
- Arbitrates point events from three requesters (hit, bonus, miss) with round-robin and req/ack handshakes.
- Sequences the game through idle, play and game-over phases, tracks the high score, and selects, blinks or blanks what the display shows.

Parameters:
- MAX_SCORE, 99, saturation ceiling for score; must be <=127.
- HIT_PTS, 1, points added per accepted hit.
- BONUS_PTS, 5, points added per accepted bonus.
- MISS_PTS, 2, points subtracted per accepted miss.
- BLINK_DIV, 25000000, clock cycles per blink half-period; must be >=2.
- OVER_BLINKS, 6, number of disp_blank toggles in game-over blink phase.

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; start/restart a game
- game_end  in  1  one-cycle pulse; end the current game
- hit_req  in  1  level request, held until hit_ack
- hit_ack  out  1  one-cycle grant pulse
- bonus_req  in  1  level request
- bonus_ack  out  1  one-cycle grant pulse
- miss_req  in  1  level request
- miss_ack  out  1  one-cycle grant pulse
- score  out  7  current score, to display datapath
- high_score  out  7  best score since reset
- disp_sel  out  1  0 = display score, 1 = display high_score
- disp_blank  out  1  1 = display digits off
- new_high  out  1  last finished game set a new high score
- state  out  2  FSM state, for debug/LEDs

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; score=0; high_score=0; all acks=0; disp_sel=1; disp_blank=0; new_high=0.
  - Round-robin pointer at hit; blink counter and toggle count=0.
- All outputs are registered.
- IDLE (00):
  - disp_sel=1; score held at 0; requests ignored, no acks.
  - start -> PLAY.
- PLAY (01):
  - Entry clears score to 0 and new_high to 0; disp_sel=0; disp_blank=0.
  - Each cycle, the arbiter grants at most one requester.
  - Eligible: req=1 and its ack not high this cycle. This masking prevents double-grant while the requester drops req.
  - Search order starts at the requester after the last granted one (hit -> bonus -> miss -> hit).
  - A grant sampled at edge N updates score and asserts that ack for exactly one cycle, both visible after edge N. Latency is 1 cycle.
  - Arithmetic uses an 8-bit intermediate.
  - Hit/bonus: score = min(score + pts, MAX_SCORE).
  - Miss: score = score < MISS_PTS ? 0 : score - MISS_PTS.
  - A grant at the saturation bound still acks; score stays unchanged.
  - start in PLAY is ignored.
  - game_end -> OVER_BLINK. game_end beats a same-cycle request: no grant, no ack.
  - On that transition, if score > high_score: high_score <= score and new_high <= 1. Equal scores do not set new_high.
- OVER_BLINK (10):
  - disp_sel=0; requests ignored, pending reqs never acked.
  - disp_blank toggles every BLINK_DIV cycles, starting from 0.
  - After OVER_BLINKS toggles: disp_blank=0 and go to OVER_HOLD.
- OVER_HOLD (11):
  - Shows the final score steady; requests ignored.
- start in OVER_BLINK or OVER_HOLD -> PLAY, with PLAY entry rules.
  - Blink counter and toggle count reset to 0; disp_blank=0 on the next cycle.
- start and game_end in the same cycle:
  - In IDLE/OVER states, start wins.
  - In PLAY, game_end wins.
- Reset mid-operation returns to reset values immediately. Any in-flight ack is dropped.

Decomposition:
- Package score_pkg holds:
  - state encodings IDLE/PLAY/OVER_BLINK/OVER_HOLD;
  - requester index constants REQ_HIT=0, REQ_BONUS=1, REQ_MISS=2.
- Sub-module rr_arb3: 3-way round-robin arbiter.
  - Inputs: req[2:0], mask[2:0], advance.
  - Outputs: one-hot grant[2:0], registered pointer.
- Blink timer and score arithmetic stay inline.

Test Plan:
- Reset/idle: clr low, then release → state=00, score=0, high_score=0, disp_sel=1. hit_req held in IDLE → no hit_ack for 20 cycles.
- Handshake: start, then hit_req held until ack → exactly one hit_ack pulse one cycle after first sampled req. score 0→1, with no second grant while req drops.
- Round-robin: all three reqs held continuously from score=10 → acks in order hit, bonus, miss, hit. Scores are 11, 16, 14, 15.
- Saturation/floor:
  - From score=97, bonus → 99, and a further hit → 99 with ack.
  - New game at score=1, miss → 0 with ack.
- Game over and high score: score=15, game_end in the same cycle as bonus_req → no bonus_ack, state=10, high_score=15, new_high=1. Next game ends at 15 → new_high=0.
- Blink and restart, with BLINK_DIV=4, OVER_BLINKS=6:
  - disp_blank toggles at cycles 4, 8, …, 24 after entry, then state=11 with disp_blank=0.
  - start mid-blink → state=01, score=0, disp_blank=0.
